// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a single-entry holding buffer; a byte queued while a
// frame is on the line follows it directly with no idle gap.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 521,
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic       tx_clk,
    input  logic       tx_rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {StIdle, StStart, StDataBurst, StStop} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is raised one count early to land on the last cycle.
    localparam logic [CNT_W-1:0] CntDone = CNT_W'(CLKS_PER_BIT - 2);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       hold_q;
    logic             hold_valid_q;

    assign tx_ready = !hold_valid_q;

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_out       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_start && !hold_valid_q) begin
                hold_q       <= tx_data;
                hold_valid_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    tx_out <= 1'b1;
                    if (hold_valid_q) begin
                        shift_q      <= hold_q;
                        hold_valid_q <= 1'b0;
                        count_q      <= '0;
                        state_q      <= StStart;
                        tx_out       <= 1'b0;
                        tx_busy      <= 1'b1;
                    end
                end
                StStart: begin
                    if (count_q == CntLast) begin
                        count_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= StDataBurst;
                        tx_out    <= shift_q[0];
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                StDataBurst: begin
                    if (count_q == CntLast) begin
                        count_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_out  <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_out    <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                StStop: begin
                    if (count_q == CntLast) begin
                        count_q <= '0;
                        if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                            state_q      <= StStart;
                            tx_out       <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CntDone) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms are built from the 8N1
// framing rules; random traffic is decoded back into bytes from the sampled line.
module tb_uart_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned CPB_SLOW = 521;
    localparam int          K_RAND   = 10;

    logic       tx_clk;
    logic       tx_rst_n;
    logic       tx_start, tx_ready, tx_out, tx_busy, tx_done;
    logic [7:0] tx_data;
    logic       s_start, s_ready, s_out, s_busy, s_done;
    logic [7:0] s_data;

    int         n_checks;
    int         n_fails;
    bit         exp_line[$];
    bit         exp_busy[$];
    bit         exp_done[$];
    bit         line_q[$];
    logic [7:0] rx_q[$];
    int         stop_errs;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .tx_clk  (tx_clk),
        .tx_rst_n(tx_rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .tx_clk  (tx_clk),
        .tx_rst_n(tx_rst_n),
        .tx_start(s_start),
        .tx_data (s_data),
        .tx_ready(s_ready),
        .tx_out  (s_out),
        .tx_busy (s_busy),
        .tx_done (s_done)
    );

    initial begin
        tx_clk = 1'b0;
        forever #5 tx_clk = ~tx_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Line model: start 0, data LSB first, stop 1, each held cpb cycles.
    function automatic void push_frame(input logic [7:0] b, input int cpb);
        bit bits[10];
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = b[k];
        bits[9] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < cpb; c++) begin
                exp_line.push_back(bits[k]);
                exp_busy.push_back(1'b1);
                exp_done.push_back(k == 9 && c == cpb - 1);
            end
        end
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_line.push_back(1'b1);
            exp_busy.push_back(1'b0);
            exp_done.push_back(1'b0);
        end
    endfunction

    function automatic void clear_exp();
        exp_line.delete();
        exp_busy.delete();
        exp_done.delete();
    endfunction

    // Recovers bytes from a sampled line by mid-bit sampling after each start bit.
    function automatic void decode_line(input int cpb);
        int         p;
        logic [7:0] b;
        p = 0;
        rx_q.delete();
        stop_errs = 0;
        while (p < line_q.size()) begin
            if (line_q[p] == 1'b0 && p + 10 * cpb <= line_q.size()) begin
                for (int k = 0; k < 8; k++) b[k] = line_q[p + (k + 1) * cpb + cpb / 2];
                if (line_q[p + 9 * cpb + cpb / 2] != 1'b1) stop_errs++;
                rx_q.push_back(b);
                p += 10 * cpb;
            end else begin
                p++;
            end
        end
    endfunction

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic test_reset();
        tx_rst_n = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        s_start  = 1'b0;
        s_data   = 8'h00;
        #1 tx_rst_n = 1'b0;
        #2;
        n_checks++; if ({tx_out, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
            n_fails++; $display("FAIL reset_outputs: out/busy/ready/done got %b want 1010",
                                {tx_out, tx_busy, tx_ready, tx_done}); end
        step(); step();
        tx_rst_n = 1'b1;
        step(); step();
        n_checks++; if ({tx_out, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
            n_fails++; $display("FAIL reset_release: out/busy/ready/done got %b want 1010",
                                {tx_out, tx_busy, tx_ready, tx_done}); end
        n_checks++; if ({s_out, s_busy, s_ready} !== 3'b101) begin
            n_fails++; $display("FAIL reset_slow: out/busy/ready got %b want 101",
                                {s_out, s_busy, s_ready}); end
    endtask

    task automatic test_single();
        int busy_cycles = 0;
        int done_cycles = 0;
        int done_at = -1;
        clear_exp();
        push_frame(8'hA5, CPB);
        push_idle(2);
        tx_data = 8'hA5; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        n_checks++; if (tx_ready !== 1'b0) begin
            n_fails++; $display("FAIL single_ready_fall: got %b want 0", tx_ready); end
        n_checks++; if (tx_out !== 1'b1) begin
            n_fails++; $display("FAIL single_out_latency: got %b want 1", tx_out); end
        step();
        n_checks++; if (tx_ready !== 1'b1) begin
            n_fails++; $display("FAIL single_ready_rise: got %b want 1", tx_ready); end
        for (int i = 0; i < exp_line.size(); i++) begin
            n_checks++;
            if ({tx_out, tx_busy, tx_done} !== {exp_line[i], exp_busy[i], exp_done[i]}) begin
                n_fails++; $display("FAIL single_cycle[%0d]: out/busy/done got %b%b%b want %b%b%b",
                    i, tx_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]); end
            if (tx_busy === 1'b1) busy_cycles++;
            if (tx_done === 1'b1) begin done_cycles++; done_at = i + 1; end
            step();
        end
        n_checks++; if (busy_cycles != 40) begin
            n_fails++; $display("FAIL single_busy_len: got %0d want 40", busy_cycles); end
        n_checks++; if (done_cycles != 1 || done_at != 40) begin
            n_fails++; $display("FAIL single_done: got %0d pulses at %0d want 1 at 40",
                                done_cycles, done_at); end
    endtask

    task automatic test_back_to_back();
        int done_idx[$];
        int busy_drops = 0;
        clear_exp();
        push_frame(8'h00, CPB);
        push_frame(8'hFF, CPB);
        push_idle(2);
        tx_data = 8'h00; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        for (int i = 0; i < exp_line.size(); i++) begin
            n_checks++;
            if ({tx_out, tx_busy, tx_done} !== {exp_line[i], exp_busy[i], exp_done[i]}) begin
                n_fails++; $display("FAIL b2b_cycle[%0d]: out/busy/done got %b%b%b want %b%b%b",
                    i, tx_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]); end
            if (i < 80 && tx_busy !== 1'b1) busy_drops++;
            if (tx_done === 1'b1) done_idx.push_back(i);
            if (i == 10) begin tx_data = 8'hFF; tx_start = 1'b1; end
            step();
            tx_start = 1'b0;
        end
        n_checks++; if (busy_drops != 0) begin
            n_fails++; $display("FAIL b2b_busy_gap: got %0d idle cycles want 0", busy_drops); end
        n_checks++;
        if (done_idx.size() != 2) begin
            n_fails++; $display("FAIL b2b_done_count: got %0d want 2", done_idx.size());
        end else if (done_idx[1] - done_idx[0] != 40) begin
            n_fails++; $display("FAIL b2b_done_spacing: got %0d want 40",
                                done_idx[1] - done_idx[0]);
        end
    endtask

    task automatic test_dropped_byte();
        clear_exp();
        push_frame(8'h12, CPB);
        push_frame(8'h34, CPB);
        push_idle(4);
        tx_data = 8'h12; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        for (int i = 0; i < exp_line.size(); i++) begin
            n_checks++;
            if ({tx_out, tx_busy, tx_done} !== {exp_line[i], exp_busy[i], exp_done[i]}) begin
                n_fails++; $display("FAIL drop_cycle[%0d]: out/busy/done got %b%b%b want %b%b%b",
                    i, tx_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]); end
            if (i == 5) begin tx_data = 8'h34; tx_start = 1'b1; end
            if (i == 15) begin
                n_checks++; if (tx_ready !== 1'b0) begin
                    n_fails++; $display("FAIL drop_ready_full: got %b want 0", tx_ready); end
                tx_data = 8'h3C; tx_start = 1'b1;
            end
            step();
            tx_start = 1'b0;
        end
        n_checks++; if (tx_ready !== 1'b1) begin
            n_fails++; $display("FAIL drop_ready_end: got %b want 1", tx_ready); end
    endtask

    task automatic test_last_cycle_accept();
        logic [7:0] first;
        first = 8'($urandom);
        clear_exp();
        push_frame(first, CPB);
        push_idle(1);
        push_frame(8'h81, CPB);
        push_idle(2);
        tx_data = first; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        for (int i = 0; i < exp_line.size(); i++) begin
            n_checks++;
            if ({tx_out, tx_busy, tx_done} !== {exp_line[i], exp_busy[i], exp_done[i]}) begin
                n_fails++; $display("FAIL last_cycle[%0d]: out/busy/done got %b%b%b want %b%b%b",
                    i, tx_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]); end
            if (i == 39) begin
                n_checks++; if (tx_ready !== 1'b1) begin
                    n_fails++; $display("FAIL last_ready: got %b want 1", tx_ready); end
                tx_data = 8'h81; tx_start = 1'b1;
            end
            step();
            tx_start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_data = 8'h00; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        n_checks++; if ({tx_out, tx_busy} !== 2'b01) begin
            n_fails++; $display("FAIL midrst_pre: out/busy got %b want 01", {tx_out, tx_busy}); end
        #2 tx_rst_n = 1'b0;
        #1;
        n_checks++; if ({tx_out, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
            n_fails++; $display("FAIL midrst_async: out/busy/ready/done got %b want 1010",
                                {tx_out, tx_busy, tx_ready, tx_done}); end
        #1 tx_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++; if ({tx_out, tx_busy, tx_ready} !== 3'b101) begin
                n_fails++; $display("FAIL midrst_idle[%0d]: out/busy/ready got %b want 101",
                                    i, {tx_out, tx_busy, tx_ready}); end
        end
    endtask

    task automatic test_random();
        logic [7:0] sent_q[$];
        int gap = 0;
        int cycles = 0;
        int sent = 0;
        line_q.delete();
        while ((sent < K_RAND || tx_busy === 1'b1 || tx_ready !== 1'b1) && cycles < 3000) begin
            line_q.push_back(tx_out);
            if (sent < K_RAND && gap == 0 && tx_ready === 1'b1) begin
                tx_data = 8'($urandom);
                tx_start = 1'b1;
                sent_q.push_back(tx_data);
                sent++;
                gap = $urandom_range(0, 45);
            end else if (tx_ready === 1'b0 && $urandom_range(0, 3) == 0) begin
                tx_data = 8'($urandom);
                tx_start = 1'b1;
            end else if (gap > 0) begin
                gap--;
            end
            step();
            tx_start = 1'b0;
            cycles++;
        end
        for (int i = 0; i < 5; i++) begin
            line_q.push_back(tx_out);
            step();
        end
        n_checks++; if (cycles >= 3000 || sent != K_RAND) begin
            n_fails++; $display("FAIL rand_timeout: got %0d sent in %0d cycles want %0d",
                                sent, cycles, K_RAND); end
        decode_line(CPB);
        n_checks++; if (stop_errs != 0) begin
            n_fails++; $display("FAIL rand_stop_bits: got %0d bad want 0", stop_errs); end
        n_checks++;
        if (rx_q.size() != sent_q.size()) begin
            n_fails++; $display("FAIL rand_count: got %0d frames want %0d",
                                rx_q.size(), sent_q.size());
        end else begin
            for (int i = 0; i < sent_q.size(); i++) begin
                n_checks++; if (rx_q[i] !== sent_q[i]) begin
                    n_fails++; $display("FAIL rand_byte[%0d]: got %02h want %02h",
                                        i, rx_q[i], sent_q[i]); end
            end
        end
    endtask

    task automatic test_default_rate();
        bit         cap[$];
        int         runs[$];
        bit         cur;
        int         len;
        int         busy_cycles = 0;
        int         done_n = 0;
        int         done_at = -1;
        logic [7:0] b;
        s_data = 8'h55; s_start = 1'b1;
        step();
        s_start = 1'b0;
        step();
        for (int i = 0; i < 10 * CPB_SLOW + 3; i++) begin
            cap.push_back(s_out);
            if (s_busy === 1'b1) busy_cycles++;
            if (s_done === 1'b1) begin done_n++; done_at = i; end
            step();
        end
        cur = cap[0];
        len = 1;
        for (int i = 1; i < cap.size(); i++) begin
            if (cap[i] == cur) len++;
            else begin runs.push_back(len); cur = cap[i]; len = 1; end
        end
        runs.push_back(len);
        n_checks++;
        if (runs.size() != 10) begin
            n_fails++; $display("FAIL rate_runs: got %0d level runs want 10", runs.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_checks++; if (runs[k] != CPB_SLOW) begin
                    n_fails++; $display("FAIL rate_bit_len[%0d]: got %0d want %0d",
                                        k, runs[k], CPB_SLOW); end
            end
        end
        for (int k = 0; k < 8; k++) b[k] = cap[(k + 1) * CPB_SLOW + CPB_SLOW / 2];
        n_checks++; if (b !== 8'h55) begin
            n_fails++; $display("FAIL rate_loopback: got %02h want 55", b); end
        n_checks++; if (busy_cycles != 10 * CPB_SLOW) begin
            n_fails++; $display("FAIL rate_frame_len: got %0d want %0d",
                                busy_cycles, 10 * CPB_SLOW); end
        n_checks++; if (done_n != 1 || done_at != 10 * CPB_SLOW - 1) begin
            n_fails++; $display("FAIL rate_done: got %0d pulses at %0d want 1 at %0d",
                                done_n, done_at, 10 * CPB_SLOW - 1); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_dropped_byte();
        test_last_cycle_accept();
        test_reset_mid_frame();
        test_random();
        test_default_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
